serdes_frame_ctrl: RTL and testbench

Frame sequencer for the serial self-test link. It frames WORD_W-bit words arriving at the deserializer and hands each captured word to self_test with a req/ack handshake. On a pass it sequences the serializer, which shifts the word back out. It runs in the bit-clock domain; crossing to and from the divided self_test clock is done by synchronizers outside this block.

---
 rtl/serdes_ctrl_pkg.sv | 28 ++
 rtl/serdes_frame_ctrl_cnt.sv | 28 ++
 rtl/serdes_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_serdes_frame_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serdes_ctrl_pkg.sv
// Shared types and sizing helpers for the serial self-test frame sequencer.
package serdes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RX   = 3'd1,
    ST_TEST = 3'd2,
    ST_LOAD = 3'd3,
    ST_TX   = 3'd4
  } state_e;

  localparam int DEF_WORD_W  = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_CNT_W   = 8;

  // One counter covers both the word length and the ack timeout, so size it for the larger.
  function automatic int phase_cnt_width(input int word_w, input int timeout);
    int a;
    int b;
    int w;
    a = $clog2(word_w);
    b = $clog2(timeout + 1);
    w = (a > b) ? a : b;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serdes_frame_ctrl_cnt.sv
// Loadable down-counter with a zero flag; times the RX/TX phases and the TEST timeout.
module ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load beats decrement; the count parks at zero until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serdes_frame_ctrl.sv
// Frame sequencer: captures a deserialized word, runs the self_test handshake, then drives the serializer.
module serdes_frame_ctrl
  import serdes_ctrl_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             st_ack_i,
  input  logic             st_pass_i,
  input  logic             clr_err_i,
  output logic             de_word_vld_o,
  output logic             st_req_o,
  output logic             tx_load_o,
  output logic             tx_en_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o
);

  localparam int              PH_W      = phase_cnt_width(WORD_W, TIMEOUT);
  localparam logic [PH_W-1:0] WORD_LAST = PH_W'(WORD_W - 1);
  localparam logic [PH_W-1:0] TMO_LAST  = PH_W'(TIMEOUT - 1);

  state_e            state_q;
  state_e            state_d;
  logic              cnt_load;
  logic [PH_W-1:0]   cnt_val;
  logic              cnt_zero;
  logic              fail_evt;
  logic              frame_evt;
  logic              timeout_evt;

  logic              de_word_vld_q;
  logic              st_req_q;
  logic              tx_load_q;
  logic              tx_en_q;
  logic              busy_q;
  logic              err_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic [CNT_W-1:0]  fail_cnt_q;

  ctrl_cnt #(
    .W (PH_W)
  ) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (state_q != ST_IDLE),
    .zero_o     (cnt_zero)
  );

  // Next-state logic; the phase counter is reloaded on every state entry that needs timing.
  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    fail_evt    = 1'b0;
    frame_evt   = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_RX;
          cnt_load = 1'b1;
          cnt_val  = WORD_LAST;
        end
      end
      ST_RX: begin
        if (cnt_zero) begin
          state_d  = ST_TEST;
          cnt_load = 1'b1;
          cnt_val  = TMO_LAST;
        end
      end
      ST_TEST: begin
        // An ack arriving on the final timeout cycle still takes priority.
        if (st_ack_i) begin
          if (st_pass_i) begin
            state_d = ST_LOAD;
          end else begin
            state_d  = ST_IDLE;
            fail_evt = 1'b1;
          end
        end else if (cnt_zero) begin
          state_d     = ST_IDLE;
          timeout_evt = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d  = ST_TX;
        cnt_load = 1'b1;
        cnt_val  = WORD_LAST;
      end
      ST_TX: begin
        if (cnt_zero) begin
          state_d   = ST_IDLE;
          frame_evt = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      de_word_vld_q <= 1'b0;
      st_req_q      <= 1'b0;
      tx_load_q     <= 1'b0;
      tx_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      frame_cnt_q   <= '0;
      fail_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      de_word_vld_q <= (state_q == ST_RX) && (state_d == ST_TEST);
      st_req_q      <= (state_d == ST_TEST);
      tx_load_q     <= (state_d == ST_LOAD);
      tx_en_q       <= (state_d == ST_TX);
      busy_q        <= (state_d != ST_IDLE);
      if (timeout_evt) begin
        err_q <= 1'b1;
      end else if (clr_err_i) begin
        err_q <= 1'b0;
      end
      if (frame_evt) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      if (fail_evt) begin
        fail_cnt_q <= fail_cnt_q + CNT_W'(1);
      end
    end
  end

  assign de_word_vld_o = de_word_vld_q;
  assign st_req_o      = st_req_q;
  assign tx_load_o     = tx_load_q;
  assign tx_en_o       = tx_en_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign fail_cnt_o    = fail_cnt_q;

endmodule

// File: tb/tb_serdes_frame_ctrl.sv
// Directed bench for serdes_frame_ctrl: exact-timing frames, a table of handshake scenarios, reset and wrap.
module tb_serdes_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_i = 1'b0, st_ack_i = 1'b0, st_pass_i = 1'b0, clr_err_i = 1'b0;
  logic       de_word_vld_o, st_req_o, tx_load_o, tx_en_o, busy_o, err_o;
  logic [7:0] frame_cnt_o, fail_cnt_o;

  logic       s8_start = 1'b0, s8_ack = 1'b0, s8_pass = 1'b0, s8_clr = 1'b0;
  logic       s8_de, s8_req, s8_load, s8_en, s8_busy, s8_err;
  logic [7:0] s8_frame, s8_fail;

  serdes_frame_ctrl #(.WORD_W(32), .TIMEOUT(255), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .st_ack_i(st_ack_i),
    .st_pass_i(st_pass_i), .clr_err_i(clr_err_i), .de_word_vld_o(de_word_vld_o),
    .st_req_o(st_req_o), .tx_load_o(tx_load_o), .tx_en_o(tx_en_o), .busy_o(busy_o),
    .err_o(err_o), .frame_cnt_o(frame_cnt_o), .fail_cnt_o(fail_cnt_o)
  );

  serdes_frame_ctrl #(.WORD_W(8), .TIMEOUT(4), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(s8_start), .st_ack_i(s8_ack),
    .st_pass_i(s8_pass), .clr_err_i(s8_clr), .de_word_vld_o(s8_de),
    .st_req_o(s8_req), .tx_load_o(s8_load), .tx_en_o(s8_en), .busy_o(s8_busy),
    .err_o(s8_err), .frame_cnt_o(s8_frame), .fail_cnt_o(s8_fail)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int ack_dly;   // TEST cycle index (0-based) carrying the ack; -1 = never
    bit pass;
    bit noise;     // drive start_i every busy cycle
    bit clr_pre;   // one-cycle clr_err_i before the frame
    bit clr_hold;  // clr_err_i held for the whole frame
    int e_req;
    int e_load;
    int e_en;
    int e_busy;
    int e_frame;
    int e_fail;
    bit e_err;
  } vec_t;

  // Runs one frame on the 32-bit DUT; measures output activity until busy_o drops.
  task automatic run_frame(input int ack_dly, input bit pass, input bit noise, input bit clr_hold,
                           output int n_de, output int n_req, output int n_load,
                           output int n_en, output int n_busy, output bit expired);
    int tc;
    int guard;
    n_de = 0; n_req = 0; n_load = 0; n_en = 0; n_busy = 0; expired = 1'b0;
    tc = 0; guard = 0;
    start_i = 1'b1; st_ack_i = 1'b0; clr_err_i = clr_hold;
    do begin
      @(negedge clk);
      start_i = 1'b0; st_ack_i = 1'b0;
      if (de_word_vld_o) n_de++;
      if (st_req_o) n_req++;
      if (tx_load_o) n_load++;
      if (tx_en_o) n_en++;
      if (busy_o) n_busy++;
      if (st_req_o) begin
        if (tc == ack_dly) begin
          st_ack_i = 1'b1; st_pass_i = pass;
        end
        tc++;
      end
      if (noise && busy_o) start_i = 1'b1;
      guard++;
    end while (busy_o && guard < 1000);
    if (guard >= 1000) expired = 1'b1;
    clr_err_i = 1'b0; st_ack_i = 1'b0; start_i = 1'b0;
  endtask

  vec_t vecs[8];
  int   n_de, n_req, n_load, n_en, n_busy, txc, guard;
  bit   expired;
  logic [4:0] act5, exp5;
  logic [5:0] act6, exp6;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ack_dly pass noise clr_pre clr_hold | req load en busy frame fail err (cumulative)
    vecs[0] = '{0,   1, 0, 0, 0,   1, 1, 32,  66, 2, 0, 0};
    vecs[1] = '{2,   0, 0, 0, 0,   3, 0,  0,  35, 2, 1, 0};
    vecs[2] = '{-1,  0, 0, 0, 0, 255, 0,  0, 287, 2, 1, 1};
    vecs[3] = '{5,   1, 0, 0, 0,   6, 1, 32,  71, 3, 1, 1};
    vecs[4] = '{254, 1, 0, 1, 0, 255, 1, 32, 320, 4, 1, 0};
    vecs[5] = '{0,   0, 0, 0, 0,   1, 0,  0,  33, 4, 2, 0};
    vecs[6] = '{-1,  0, 0, 0, 1, 255, 0,  0, 287, 4, 2, 1};
    vecs[7] = '{0,   1, 1, 0, 0,   1, 1, 32,  66, 5, 2, 1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {de_word_vld_o, st_req_o, tx_load_o, tx_en_o, busy_o, err_o, frame_cnt_o, fail_cnt_o}, 0);
    chk("reset_outputs_w8", {s8_de, s8_req, s8_load, s8_en, s8_busy, s8_err, s8_frame, s8_fail}, 0);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);

    // Exact timing, start at offset 0 and ack in the fourth TEST cycle (offset 36).
    for (int k = 0; k <= 72; k++) begin
      act5 = {de_word_vld_o, st_req_o, tx_load_o, tx_en_o, busy_o};
      exp5 = {k == 33, (k >= 33) && (k <= 36), k == 37, (k >= 38) && (k <= 69), (k >= 1) && (k <= 69)};
      chk($sformatf("t1_off%0d_{vld,req,load,en,busy}", k), act5, exp5);
      start_i = (k == 0); st_ack_i = (k == 36); st_pass_i = 1'b1;
      @(negedge clk);
    end
    chk("t1_frame_cnt", frame_cnt_o, 1);
    chk("t1_fail_cnt", fail_cnt_o, 0);
    $display("timing frame: frame_cnt=%0d fail_cnt=%0d", frame_cnt_o, fail_cnt_o);

    foreach (vecs[i]) begin
      if (vecs[i].clr_pre) begin
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
      end
      run_frame(vecs[i].ack_dly, vecs[i].pass, vecs[i].noise, vecs[i].clr_hold,
                n_de, n_req, n_load, n_en, n_busy, expired);
      chk($sformatf("v%0d_bound", i), expired, 0);
      chk($sformatf("v%0d_de_pulses", i), n_de, 1);
      chk($sformatf("v%0d_req_cycles", i), n_req, vecs[i].e_req);
      chk($sformatf("v%0d_load_pulses", i), n_load, vecs[i].e_load);
      chk($sformatf("v%0d_en_cycles", i), n_en, vecs[i].e_en);
      chk($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].e_busy);
      chk($sformatf("v%0d_frame_cnt", i), frame_cnt_o, vecs[i].e_frame);
      chk($sformatf("v%0d_fail_cnt", i), fail_cnt_o, vecs[i].e_fail);
      chk($sformatf("v%0d_err", i), err_o, vecs[i].e_err);
      $display("vec %0d: ack_dly=%0d pass=%0d req=%0d load=%0d en=%0d busy=%0d frame=%0d fail=%0d err=%0d",
               i, vecs[i].ack_dly, vecs[i].pass, n_req, n_load, n_en, n_busy, frame_cnt_o, fail_cnt_o, err_o);
    end

    // Clear the sticky error with no frame in flight.
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    @(negedge clk);
    chk("clr_err", err_o, 0);
    $display("clr_err: err=%0d", err_o);

    // Asynchronous reset on the 20th TX cycle.
    start_i = 1'b1; txc = 0; guard = 0;
    while (txc < 20 && guard < 200) begin
      @(negedge clk);
      start_i = 1'b0;
      st_ack_i = st_req_o; st_pass_i = 1'b1;
      if (tx_en_o) txc++;
      guard++;
    end
    chk("rst_bound", guard < 200, 1);
    st_ack_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {de_word_vld_o, st_req_o, tx_load_o, tx_en_o, busy_o, err_o, frame_cnt_o, fail_cnt_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", {busy_o, tx_en_o, frame_cnt_o}, 0);
    run_frame(0, 1'b1, 1'b0, 1'b0, n_de, n_req, n_load, n_en, n_busy, expired);
    chk("rst_post_en_cycles", n_en, 32);
    chk("rst_post_frame_cnt", frame_cnt_o, 1);
    $display("reset mid-TX: post frame en=%0d frame=%0d", n_en, frame_cnt_o);

    // Counter wrap: 254 more frames reach 255, one more wraps to 0.
    for (int f = 0; f < 254; f++) begin
      run_frame(0, 1'b1, 1'b0, 1'b0, n_de, n_req, n_load, n_en, n_busy, expired);
      if (expired) chk($sformatf("wrap_bound_%0d", f), expired, 0);
    end
    chk("wrap_255", frame_cnt_o, 255);
    run_frame(0, 1'b1, 1'b0, 1'b0, n_de, n_req, n_load, n_en, n_busy, expired);
    chk("wrap_to_0", frame_cnt_o, 0);
    chk("wrap_fail_cnt", fail_cnt_o, 0);
    $display("wrap: frame_cnt=%0d after 256 frames", frame_cnt_o);

    // WORD_W=8 / TIMEOUT=4 instance: immediate-ack frame, then a timeout frame.
    for (int k = 0; k <= 20; k++) begin
      act6 = {s8_de, s8_req, s8_load, s8_en, s8_busy, s8_err};
      exp6 = {k == 9, k == 9, k == 10, (k >= 11) && (k <= 18), (k >= 1) && (k <= 18), 1'b0};
      chk($sformatf("w8_pass_off%0d_{vld,req,load,en,busy,err}", k), act6, exp6);
      s8_start = (k == 0); s8_ack = (k == 9); s8_pass = 1'b1;
      @(negedge clk);
    end
    chk("w8_frame_cnt", s8_frame, 1);
    for (int k = 0; k <= 16; k++) begin
      act6 = {s8_de, s8_req, s8_load, s8_en, s8_busy, s8_err};
      exp6 = {k == 9, (k >= 9) && (k <= 12), 1'b0, 1'b0, (k >= 1) && (k <= 12), k >= 13};
      chk($sformatf("w8_tmo_off%0d_{vld,req,load,en,busy,err}", k), act6, exp6);
      s8_start = (k == 0); s8_ack = 1'b0;
      @(negedge clk);
    end
    chk("w8_tmo_counters", {s8_frame, s8_fail}, {8'd1, 8'd0});
    $display("w8: frame=%0d fail=%0d err=%0d", s8_frame, s8_fail, s8_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
